// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states and ALU opcodes.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic. ALU_ARB_RR_EN selects round-robin; otherwise fixed priority to requester 0.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
    // prio_p0 high means requester 1 wins the next tie
    logic prio_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_p0 <= 1'b0;
        end else if (update) begin
            prio_p0 <= gnt[0];
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_p0 ? 2'b10 : 2'b01;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, update};

    always_comb begin
        gnt = {req[1] & ~req[0], req[0]};
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters, one transaction in flight at a time.
// Arbitration policy set by macro ALU_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_mode,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_mode,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [N-1:0] rsp0_data,
    output logic         rsp0_zero,
    output logic         rsp0_carry,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp1_data,
    output logic         rsp1_zero,
    output logic         rsp1_carry,
    output logic         alu_enable,
    output logic [2:0]   alu_mode,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_out,
    input  logic         alu_zero,
    input  logic         alu_carry,
    output logic         busy
);

    arb_state_t   state, state_nxt;
    logic [1:0]   req_vec;
    logic [1:0]   gnt;
    logic         accept;
    logic         rsp_fire;

    logic         gnt_idx_p0;
    logic [2:0]   op_mode_p0;
    logic [N-1:0] op_a_p0;
    logic [N-1:0] op_b_p0;
    logic [N-1:0] rsp_data_p1;
    logic         rsp_zero_p1;
    logic         rsp_carry_p1;

    assign req_vec = {req1_valid, req0_valid} & {2{state == ST_IDLE}};
    assign accept  = |gnt;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_vec),
        .update (accept),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        alu_enable = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state != ST_IDLE);
        rsp_fire   = gnt_idx_p0 ? rsp1_ready : rsp0_ready;
        unique case (state)
            ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                alu_enable = 1'b1;
                state_nxt  = ST_CAPTURE;
            end
            ST_CAPTURE: state_nxt = ST_RESPOND;
            ST_RESPOND: begin
                rsp0_valid = ~gnt_idx_p0;
                rsp1_valid = gnt_idx_p0;
                if (rsp_fire) state_nxt = ST_IDLE;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: operation latched on accept, held on the ALU bus until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_idx_p0 <= 1'b0;
            op_mode_p0 <= 3'b000;
            op_a_p0    <= '0;
            op_b_p0    <= '0;
        end else if (accept) begin
            gnt_idx_p0 <= gnt[1];
            op_mode_p0 <= gnt[1] ? req1_mode : req0_mode;
            op_a_p0    <= gnt[1] ? req1_a    : req0_a;
            op_b_p0    <= gnt[1] ? req1_b    : req0_b;
        end
    end

    // Stage p1: ALU result captured the cycle after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_p1  <= '0;
            rsp_zero_p1  <= 1'b0;
            rsp_carry_p1 <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            rsp_data_p1  <= alu_out;
            rsp_zero_p1  <= alu_zero;
            rsp_carry_p1 <= alu_carry;
        end
    end

    assign alu_mode   = op_mode_p0;
    assign alu_a      = op_a_p0;
    assign alu_b      = op_b_p0;
    assign rsp0_data  = rsp_data_p1;
    assign rsp0_zero  = rsp_zero_p1;
    assign rsp0_carry = rsp_carry_p1;
    assign rsp1_data  = rsp_data_p1;
    assign rsp1_zero  = rsp_zero_p1;
    assign rsp1_carry = rsp_carry_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU attached.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_mode, req1_mode;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [N-1:0] rsp0_data, rsp1_data;
    logic         rsp0_zero, rsp0_carry, rsp1_zero, rsp1_carry;
    logic         alu_enable;
    logic [2:0]   alu_mode;
    logic [N-1:0] alu_a, alu_b, alu_out;
    logic         alu_zero, alu_carry;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_mode  (req0_mode),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_mode  (req1_mode),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_zero  (rsp0_zero),
        .rsp0_carry (rsp0_carry),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_zero  (rsp1_zero),
        .rsp1_carry (rsp1_carry),
        .alu_enable (alu_enable),
        .alu_mode   (alu_mode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: carry is carry-out / borrow; CMP leaves alu_out untouched
    logic [N:0] alu_res;
    logic       alu_z_n, alu_c_n;

    always_comb begin
        alu_res = {1'b0, alu_out};
        case (alu_mode)
            OP_ADD:  alu_res = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            OP_INC:  alu_res = {1'b0, alu_a} + 9'd1;
            OP_DEC:  alu_res = {1'b0, alu_a} - 9'd1;
            OP_AND:  alu_res = {1'b0, alu_a & alu_b};
            OP_OR:   alu_res = {1'b0, alu_a | alu_b};
            OP_XOR:  alu_res = {1'b0, alu_a ^ alu_b};
            default: alu_res = {1'b0, alu_out};
        endcase
        alu_z_n = (alu_res[N-1:0] == '0);
        alu_c_n = alu_res[N];
        if (alu_mode == OP_CMP) begin
            alu_z_n = (alu_a == alu_b);
            alu_c_n = (alu_a < alu_b);
        end
    end

    always_ff @(posedge clk) begin
        if (alu_enable) begin
            alu_out   <= alu_res[N-1:0];
            alu_zero  <= alu_z_n;
            alu_carry <= alu_c_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for ready, return one cycle after the accept edge
    task automatic send(input int k, input logic [2:0] m, input logic [N-1:0] a, input logic [N-1:0] b);
        if (k == 0) begin
            req0_mode = m; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_mode = m; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 10 && !(k == 0 ? req0_ready : req1_ready); i++) tick();
        chk1("accept_ready", (k == 0 ? req0_ready : req1_ready), 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int k);
        for (int i = 0; i < 8 && !(k == 0 ? rsp0_valid : rsp1_valid); i++) tick();
        chk1("rsp_valid", (k == 0 ? rsp0_valid : rsp1_valid), 1'b1);
    endtask

    task automatic finish_rsp(input int k);
        if (k == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk1("rsp_drop", (k == 0 ? rsp0_valid : rsp1_valid), 1'b0);
        chk1("idle_busy", busy, 1'b0);
    endtask

    int   who [4];
    int   when[4];
    int   exp_who[4];
    int   n_rsp;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_mode = 3'b000; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_mode = 3'b000; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #3;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_alu_en", alu_enable, 1'b0);
        chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk8("rst_rsp0_data", rsp0_data, 8'h00);
        chk8("rst_alu_a", alu_a, 8'h00);
        chk8("rst_alu_mode", {5'b0, alu_mode}, 8'h00);
        chk1("rst_req0_ready", req0_ready, 1'b0);
        #4;
        rst_n = 1'b1;
        tick();

        // Idle with no requests
        chk1("idle_req0_ready", req0_ready, 1'b0);
        chk1("idle_req1_ready", req1_ready, 1'b0);

        // req0 ADD 0F+01 with exact latency
        req0_mode = OP_ADD; req0_a = 8'h0F; req0_b = 8'h01; req0_valid = 1'b1;
        #1;
        chk1("t1_req0_ready", req0_ready, 1'b1);
        chk1("t1_req1_ready", req1_ready, 1'b0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk1("t1_issue_en", alu_enable, 1'b1);
        chk8("t1_issue_a", alu_a, 8'h0F);
        chk8("t1_issue_b", alu_b, 8'h01);
        chk8("t1_issue_mode", {5'b0, alu_mode}, 8'h00);
        chk1("t1_issue_busy", busy, 1'b1);
        chk1("t1_issue_ready", req0_ready, 1'b0);
        tick();
        chk1("t1_capture_en", alu_enable, 1'b0);
        chk1("t1_capture_rsp", rsp0_valid, 1'b0);
        tick();
        chk1("t1_rsp0_valid", rsp0_valid, 1'b1);
        chk8("t1_rsp0_data", rsp0_data, 8'h10);
        chk1("t1_rsp0_carry", rsp0_carry, 1'b0);
        chk1("t1_rsp0_zero", rsp0_zero, 1'b0);
        chk1("t1_rsp1_valid", rsp1_valid, 1'b0);
        finish_rsp(0);

        // req1 ADD FF+01 wraps to zero with carry
        send(1, OP_ADD, 8'hFF, 8'h01);
        wait_rsp(1);
        chk8("t2_rsp1_data", rsp1_data, 8'h00);
        chk1("t2_rsp1_carry", rsp1_carry, 1'b1);
        chk1("t2_rsp1_zero", rsp1_zero, 1'b1);
        chk1("t2_rsp0_valid", rsp0_valid, 1'b0);
        finish_rsp(1);

        // XOR, then CMP forwards the untouched ALU output with fresh flags
        send(0, OP_XOR, 8'hF0, 8'h3C);
        wait_rsp(0);
        chk8("t3_xor_data", rsp0_data, 8'hCC);
        chk1("t3_xor_zero", rsp0_zero, 1'b0);
        finish_rsp(0);
        send(1, OP_CMP, 8'h03, 8'h07);
        wait_rsp(1);
        chk8("t4_cmp_data", rsp1_data, 8'hCC);
        chk1("t4_cmp_zero", rsp1_zero, 1'b0);
        chk1("t4_cmp_carry", rsp1_carry, 1'b1);
        finish_rsp(1);
        send(0, OP_SUB, 8'h05, 8'h07);
        wait_rsp(0);
        chk8("t5_sub_data", rsp0_data, 8'hFE);
        chk1("t5_sub_carry", rsp0_carry, 1'b1);
        finish_rsp(0);

        // Response back-pressure with new requests pending
        send(0, OP_AND, 8'hAA, 8'h0F);
        wait_rsp(0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_mode = OP_INC; req1_a = 8'h01; req1_b = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("stall_rsp0_valid", rsp0_valid, 1'b1);
            chk8("stall_rsp0_data", rsp0_data, 8'h0A);
            chk1("stall_req0_ready", req0_ready, 1'b0);
            chk1("stall_req1_ready", req1_ready, 1'b0);
            chk1("stall_alu_en", alu_enable, 1'b0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        finish_rsp(0);

        // Reset during CAPTURE aborts the transaction
        send(1, OP_OR, 8'h12, 8'h21);
        tick();
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_alu_en", alu_enable, 1'b0);
        chk1("abort_rsp1_valid", rsp1_valid, 1'b0);
        chk8("abort_rsp1_data", rsp1_data, 8'h00);
        chk1("abort_rsp1_zero", rsp1_zero, 1'b0);
        chk8("abort_alu_a", alu_a, 8'h00);
        chk8("abort_alu_b", alu_b, 8'h00);
        chk8("abort_alu_mode", {5'b0, alu_mode}, 8'h00);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("abort_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
        end

        // Both requesters valid continuously, responses always consumed
`ifdef ALU_ARB_RR_EN
        exp_who = '{0, 1, 0, 1};
`else
        exp_who = '{0, 0, 0, 0};
`endif
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_mode = OP_ADD; req0_a = 8'h01; req0_b = 8'h01;
        req1_mode = OP_ADD; req1_a = 8'h02; req1_b = 8'h02;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 24 && n_rsp < 4; c++) begin
            #1;
            if (rsp0_valid) begin
                chk8("rr_rsp0_data", rsp0_data, 8'h02);
                who[n_rsp] = 0; when[n_rsp] = c; n_rsp++;
            end else if (rsp1_valid) begin
                chk8("rr_rsp1_data", rsp1_data, 8'h04);
                who[n_rsp] = 1; when[n_rsp] = c; n_rsp++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        chk8("rr_count", 8'(n_rsp), 8'd4);
        for (int j = 0; j < n_rsp; j++) begin
            chk8("rr_grant", 8'(who[j]), 8'(exp_who[j]));
            if (j > 0) chk8("rr_spacing", 8'(when[j] - when[j-1]), 8'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, default 8, operand/result width; SHALL match the width of the shared ALU.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 reqK_valid  in  1  (K=0,1) requester K has an operation pending.
REQ-005 reqK_ready  out  1  arbiter accepts requester K's operation this cycle.
REQ-006 reqK_mode  in  3  ALU opcode (ADD 000, SUB 001, INC 010, DEC 011, AND 100, OR 101, XOR 110, CMP 111).
REQ-007 reqK_a, reqK_b  in  N  operands.
REQ-008 rspK_valid  out  1  result for requester K is available.
REQ-009 rspK_ready  in  1  requester K consumes the result.
REQ-010 rspK_data  out  N; rspK_zero, rspK_carry  out  1 each  captured ALU result and flags.
REQ-011 alu_enable  out  1; alu_mode  out  3; alu_a, alu_b  out  N  drive the shared ALU.
REQ-012 alu_out  in  N; alu_zero, alu_carry  in  1  ALU registered outputs (update on the edge where alu_enable is sampled high).
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, ISSUE, CAPTURE, RESPOND; one transaction in flight at a time.
REQ-015 IDLE: if any reqK_valid, grant one requester; reqK_ready high combinationally for the granted requester only; on valid&&ready latch mode, a, b and the grant index; next state ISSUE.
REQ-016 IDLE with no valid: stay in IDLE; both ready outputs low.
REQ-017 ISSUE: alu_enable=1 for exactly one cycle with the latched mode and operands; next state CAPTURE.
REQ-018 CAPTURE: register alu_out, alu_zero, alu_carry into the response registers; next state RESPOND.
REQ-019 RESPOND: rspK_valid high for the granted K only, with data/flags held stable until rspK_ready; on rspK_valid&&rspK_ready go to IDLE.
REQ-020 Latency: accept at edge T -> alu_enable high in cycle T+1 -> rspK_valid high from cycle T+3; back-to-back throughput is one op per 4 cycles with rsp_ready tied high.
REQ-021 alu_enable SHALL be low in all states other than ISSUE; alu_mode/alu_a/alu_b SHALL hold the last latched values.
REQ-022 CMP (111): rspK_data is forwarded from alu_out unchanged (ALU leaves it untouched); flags are valid.
REQ-023 Requests arriving while busy are not accepted (ready low); requesters SHALL hold valid and payload until accepted.
REQ-024 No arithmetic inside the arbiter; all N-bit values pass through unmodified.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, reqK_ready=0, rspK_valid=0, rspK_data=0, rspK_zero=0, rspK_carry=0, alu_enable=0, alu_mode=000, alu_a=0, alu_b=0, busy=0, round-robin pointer favours requester 0.
REQ-026 Reset asserted mid-transaction aborts it; no response is delivered for the aborted operation.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous valid, grant the requester not served last; pointer updates on each accept.
REQ-028 Macro ALU_ARB_RR_EN undefined: fixed priority; requester 0 always wins a tie; no pointer state is instantiated.

Structure
REQ-029 Shared package alu_arb_pkg SHALL hold the FSM state enumeration and the eight 3-bit ALU opcode constants.
REQ-030 Grant logic SHALL be a sub-module rr_arb2 (2 requests in, one-hot grant out, pointer update input) compiled per ALU_ARB_RR_EN.

Verification
REQ-031 Single req0 ADD a=8'h0F b=8'h01 -> alu_enable one cycle after accept; rsp0_valid 3 cycles after accept with data 8'h10, carry 0.
REQ-032 req1 ADD a=8'hFF b=8'h01 -> rsp1_data 8'h00, rsp1_carry 1, rsp1_zero 1; rsp0_valid stays 0.
REQ-033 Both valid every cycle, RR enabled -> grants alternate 0,1,0,1 starting with 0; RR disabled -> requester 0 served every time.
REQ-034 rsp0_ready held low 5 cycles in RESPOND -> rsp0_valid/data stable, both reqK_ready low, alu_enable low throughout.
REQ-035 rst_n pulsed low during CAPTURE -> all outputs at reset values immediately; no rspK_valid afterwards until a new accept.
